// File: rtl/smt_fetch_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : smt_fetch_scheduler_if
// Brief   : Thread status, miss report and fetch-select bundle of the scheduler
// Rev     : 1.0
// ============================================================================
interface smt_fetch_scheduler_if #(
   parameter int NUM_THREADS     = 4,
   parameter int THREAD_ID_WIDTH = 2
);
   logic [NUM_THREADS-1:0]     i_thread_active;
   logic [NUM_THREADS-1:0]     i_thread_wait;
   logic                       i_miss_valid;
   logic [THREAD_ID_WIDTH-1:0] i_miss_thread;
   logic [THREAD_ID_WIDTH-1:0] o_thread;
   logic                       o_fetch_valid;
   logic                       o_idle;
   logic [NUM_THREADS-1:0]     o_blocked;

   modport master (
      output i_thread_active, i_thread_wait, i_miss_valid, i_miss_thread,
      input  o_thread, o_fetch_valid, o_idle, o_blocked
   );

   modport slave (
      input  i_thread_active, i_thread_wait, i_miss_valid, i_miss_thread,
      output o_thread, o_fetch_valid, o_idle, o_blocked
   );
endinterface
`default_nettype wire

// File: rtl/smt_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : smt_fetch_scheduler
// Brief   : Round-robin SMT fetch thread picker with per-thread miss blocking
// Rev     : 1.0
// ============================================================================
module smt_fetch_scheduler #(
   parameter int NUM_THREADS     = 4,
   parameter int THREAD_ID_WIDTH = 2,
   parameter int MISS_PENALTY    = 8,
   parameter int CNT_WIDTH       = 4
) (
   input  wire logic               i_Clk,
   input  wire logic               i_Reset_n,
   input  wire logic               i_Stall,
   input  wire logic               i_Flush,
   smt_fetch_scheduler_if.slave    bus
);

   localparam logic [CNT_WIDTH-1:0]       c_PENALTY  = CNT_WIDTH'(MISS_PENALTY);
   localparam logic [THREAD_ID_WIDTH-1:0] c_LAST_RST = THREAD_ID_WIDTH'(NUM_THREADS - 1);

   logic [CNT_WIDTH-1:0]       r_cnt      [NUM_THREADS];
   logic [CNT_WIDTH-1:0]       w_cnt_next [NUM_THREADS];
   logic [NUM_THREADS-1:0]     w_blocked_next;
   logic [NUM_THREADS-1:0]     w_elig;
   logic [THREAD_ID_WIDTH-1:0] r_last;
   logic [THREAD_ID_WIDTH-1:0] w_pick;
   logic [THREAD_ID_WIDTH-1:0] w_cand;
   logic                       w_any;

   logic [THREAD_ID_WIDTH-1:0] r_thread;
   logic                       r_fetch_valid;
   logic                       r_idle;
   logic [NUM_THREADS-1:0]     r_blocked;

   // A miss reported this cycle masks its thread immediately and reloads its counter.
   always_comb begin
      w_elig         = '0;
      w_blocked_next = '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
         w_cnt_next[t] = r_cnt[t];
         if (bus.i_miss_valid && (bus.i_miss_thread == THREAD_ID_WIDTH'(t)))
            w_cnt_next[t] = c_PENALTY;
         else if (r_cnt[t] != '0)
            w_cnt_next[t] = r_cnt[t] - CNT_WIDTH'(1);
         w_blocked_next[t] = (w_cnt_next[t] != '0);
         w_elig[t] = bus.i_thread_active[t] && !bus.i_thread_wait[t] && (r_cnt[t] == '0)
                     && !(bus.i_miss_valid && (bus.i_miss_thread == THREAD_ID_WIDTH'(t)));
      end
   end

   // Scan from the farthest candidate back so the nearest one after r_last wins;
   // the final offset wraps to r_last itself.
   always_comb begin
      w_any  = |w_elig;
      w_pick = r_last;
      w_cand = r_last;
      for (int k = NUM_THREADS; k >= 1; k--) begin
         w_cand = r_last + THREAD_ID_WIDTH'(k);
         if (w_elig[w_cand])
            w_pick = w_cand;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         for (int t = 0; t < NUM_THREADS; t++)
            r_cnt[t] <= '0;
         r_blocked     <= '0;
         r_thread      <= '0;
         r_fetch_valid <= 1'b0;
         r_idle        <= 1'b0;
         r_last        <= c_LAST_RST;
      end else begin
         for (int t = 0; t < NUM_THREADS; t++)
            r_cnt[t] <= w_cnt_next[t];
         r_blocked <= w_blocked_next;
         if (!i_Stall) begin
            if (i_Flush) begin
               r_fetch_valid <= 1'b0;
               r_idle        <= 1'b0;
            end else if (w_any) begin
               r_thread      <= w_pick;
               r_last        <= w_pick;
               r_fetch_valid <= 1'b1;
               r_idle        <= 1'b0;
            end else begin
               r_fetch_valid <= 1'b0;
               r_idle        <= 1'b1;
            end
         end
      end
   end

   assign bus.o_thread      = r_thread;
   assign bus.o_fetch_valid = r_fetch_valid;
   assign bus.o_idle        = r_idle;
   assign bus.o_blocked     = r_blocked;

endmodule
`default_nettype wire

// File: tb/tb_smt_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_smt_fetch_scheduler
// Brief   : Self-checking bench for smt_fetch_scheduler against a cycle model
// Rev     : 1.0
// ============================================================================
module tb_smt_fetch_scheduler;

   localparam int c_PEN = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic stall;
   logic flush;
   int   checks = 0;
   int   errors = 0;

   smt_fetch_scheduler_if #(.NUM_THREADS(4), .THREAD_ID_WIDTH(2)) bus ();

   smt_fetch_scheduler #(
      .NUM_THREADS(4), .THREAD_ID_WIDTH(2), .MISS_PENALTY(c_PEN), .CNT_WIDTH(4)
   ) u_dut (
      .i_Clk     (clk),
      .i_Reset_n (rst_n),
      .i_Stall   (stall),
      .i_Flush   (flush),
      .bus       (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model state
   int         m_cnt [4];
   int         m_last;
   logic [1:0] e_thread;
   logic       e_valid;
   logic       e_idle;
   logic [3:0] e_blocked;
   logic [7:0] exp_v;
   logic [7:0] act_v;

   assign act_v = {bus.o_thread, bus.o_fetch_valid, bus.o_idle, bus.o_blocked};

   task automatic model_reset();
      for (int t = 0; t < 4; t++) m_cnt[t] = 0;
      m_last = 3; e_thread = 2'd0; e_valid = 1'b0; e_idle = 1'b0; e_blocked = 4'd0;
      exp_v = {e_thread, e_valid, e_idle, e_blocked};
   endtask

   // Evaluate the inputs that the next rising edge will sample.
   task automatic model_step();
      bit el [4];
      bit any;
      int c;
      any = 1'b0;
      c   = m_last;
      for (int t = 0; t < 4; t++)
         el[t] = bus.i_thread_active[t] && !bus.i_thread_wait[t] && (m_cnt[t] == 0)
                 && !(bus.i_miss_valid && (int'(bus.i_miss_thread) == t));
      for (int k = 1; k <= 4; k++)
         if (!any && el[(m_last + k) % 4]) begin
            c   = (m_last + k) % 4;
            any = 1'b1;
         end
      for (int t = 0; t < 4; t++) begin
         if (bus.i_miss_valid && (int'(bus.i_miss_thread) == t)) m_cnt[t] = c_PEN;
         else if (m_cnt[t] > 0) m_cnt[t] = m_cnt[t] - 1;
         e_blocked[t] = (m_cnt[t] != 0);
      end
      if (!stall) begin
         if (flush) begin
            e_valid = 1'b0; e_idle = 1'b0;
         end else if (any) begin
            e_thread = 2'(c); m_last = c; e_valid = 1'b1; e_idle = 1'b0;
         end else begin
            e_valid = 1'b0; e_idle = 1'b1;
         end
      end
      exp_v = {e_thread, e_valid, e_idle, e_blocked};
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs(input logic [3:0] act);
      bus.i_thread_active = act;
      bus.i_thread_wait   = 4'd0;
      bus.i_miss_valid    = 1'b0;
      bus.i_miss_thread   = 2'd0;
      stall               = 1'b0;
      flush               = 1'b0;
   endtask

   task automatic test_reset();
      quiet_inputs(4'b1111);
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (act_v !== 8'h00) begin
         errors++; $display("FAIL reset_state: got %h expected %h", act_v, 8'h00);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_round_robin();
      int seq [6] = '{0, 1, 2, 3, 0, 1};
      quiet_inputs(4'b1111);
      for (int i = 0; i < 6; i++) begin
         cycle();
         checks++;
         if ({bus.o_thread, bus.o_fetch_valid} !== {2'(seq[i]), 1'b1}) begin
            errors++;
            $display("FAIL rr_seq[%0d]: got thread %0d valid %b expected thread %0d valid 1",
                     i, bus.o_thread, bus.o_fetch_valid, seq[i]);
         end
         checks++;
         if (act_v !== exp_v) begin
            errors++; $display("FAIL rr_model[%0d]: got %h expected %h", i, act_v, exp_v);
         end
      end
   endtask

   task automatic test_alternate_idle();
      int seq [3] = '{3, 1, 3};
      quiet_inputs(4'b1010);
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++;
         if ({bus.o_thread, bus.o_fetch_valid} !== {2'(seq[i]), 1'b1}) begin
            errors++;
            $display("FAIL alt_seq[%0d]: got thread %0d valid %b expected thread %0d valid 1",
                     i, bus.o_thread, bus.o_fetch_valid, seq[i]);
         end
      end
      quiet_inputs(4'b0000);
      for (int i = 0; i < 2; i++) begin
         cycle();
         checks++;
         if ({bus.o_thread, bus.o_fetch_valid, bus.o_idle} !== {2'd3, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL idle[%0d]: got thread %0d valid %b idle %b expected 3 0 1",
                     i, bus.o_thread, bus.o_fetch_valid, bus.o_idle);
         end
      end
   endtask

   task automatic test_miss();
      int blk_cycles = 0;
      int bad_grants = 0;
      quiet_inputs(4'b1111);
      cycle(); // grants 0
      cycle(); // grants 1
      bus.i_miss_valid  = 1'b1;
      bus.i_miss_thread = 2'd2;
      cycle();
      checks++;
      if (bus.o_thread !== 2'd3) begin
         errors++; $display("FAIL miss_skip: got thread %0d expected 3", bus.o_thread);
      end
      if (bus.o_blocked[2]) blk_cycles++;
      bus.i_miss_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (bus.o_blocked[2]) blk_cycles++;
         if (i < 7 && bus.o_thread == 2'd2) bad_grants++;
         checks++;
         if (act_v !== exp_v) begin
            errors++; $display("FAIL miss_model[%0d]: got %h expected %h", i, act_v, exp_v);
         end
      end
      checks++;
      if (blk_cycles !== 8) begin
         errors++; $display("FAIL miss_block_len: got %0d cycles expected 8", blk_cycles);
      end
      checks++;
      if (bad_grants !== 0) begin
         errors++; $display("FAIL miss_grant_blocked: got %0d grants expected 0", bad_grants);
      end
   endtask

   task automatic test_stall();
      logic [1:0] held;
      quiet_inputs(4'b1111);
      bus.i_miss_valid  = 1'b1;
      bus.i_miss_thread = 2'd1;
      cycle();
      bus.i_miss_valid = 1'b0;
      repeat (3) cycle(); // counter now 5
      held  = bus.o_thread;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++;
         if ({bus.o_thread, bus.o_fetch_valid, bus.o_blocked[1]} !== {held, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got thread %0d valid %b blk %b expected %0d 1 1",
                     i, bus.o_thread, bus.o_fetch_valid, bus.o_blocked[1], held);
         end
      end
      stall = 1'b0;
      cycle();
      checks++;
      if ({bus.o_blocked[1], bus.o_thread} !== {1'b1, 2'(held + 2'd1 == 2'd1 ? held + 2'd2 : held + 2'd1)}) begin
         errors++;
         $display("FAIL stall_resume: got blk %b thread %0d expected blk 1 thread after %0d",
                  bus.o_blocked[1], bus.o_thread, held);
      end
      cycle();
      checks++;
      if (bus.o_blocked[1] !== 1'b0) begin
         errors++; $display("FAIL stall_count: got blk %b expected 0", bus.o_blocked[1]);
      end
      checks++;
      if (act_v !== exp_v) begin
         errors++; $display("FAIL stall_model: got %h expected %h", act_v, exp_v);
      end
   endtask

   task automatic test_stall_flush();
      logic [1:0] held;
      quiet_inputs(4'b1111);
      cycle();
      held  = bus.o_thread;
      stall = 1'b1;
      flush = 1'b1;
      cycle();
      checks++;
      if ({bus.o_thread, bus.o_fetch_valid} !== {held, 1'b1}) begin
         errors++;
         $display("FAIL stall_flush: got thread %0d valid %b expected %0d 1",
                  bus.o_thread, bus.o_fetch_valid, held);
      end
      stall = 1'b0;
      cycle();
      checks++;
      if ({bus.o_thread, bus.o_fetch_valid, bus.o_idle} !== {held, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL flush_only: got thread %0d valid %b idle %b expected %0d 0 0",
                  bus.o_thread, bus.o_fetch_valid, bus.o_idle, held);
      end
      flush = 1'b0;
      cycle();
      checks++;
      if ({bus.o_thread, bus.o_fetch_valid} !== {2'(held + 2'd1), 1'b1}) begin
         errors++;
         $display("FAIL flush_next: got thread %0d valid %b expected %0d 1",
                  bus.o_thread, bus.o_fetch_valid, 2'(held + 2'd1));
      end
   endtask

   task automatic test_reset_mid();
      quiet_inputs(4'b1111);
      bus.i_miss_valid  = 1'b1;
      bus.i_miss_thread = 2'd0;
      cycle();
      bus.i_miss_valid = 1'b0;
      repeat (4) cycle(); // counter now 4
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (act_v !== 8'h00) begin
         errors++; $display("FAIL async_reset: got %h expected %h", act_v, 8'h00);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cycle();
         checks++;
         if ({bus.o_thread, bus.o_fetch_valid, bus.o_blocked} !== {2'(i), 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL post_reset[%0d]: got thread %0d valid %b blk %b expected %0d 1 0000",
                     i, bus.o_thread, bus.o_fetch_valid, bus.o_blocked, i);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         bus.i_thread_active = 4'($urandom_range(0, 15));
         bus.i_thread_wait   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         bus.i_miss_valid    = ($urandom_range(0, 3) == 0);
         bus.i_miss_thread   = 2'($urandom_range(0, 3));
         stall               = ($urandom_range(0, 4) == 0);
         flush               = ($urandom_range(0, 9) == 0);
         cycle();
         checks++;
         if (act_v !== exp_v) begin
            errors++; $display("FAIL random[%0d]: got %h expected %h", i, act_v, exp_v);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      quiet_inputs(4'b0000);
      test_reset();
      test_round_robin();
      test_alternate_idle();
      test_miss();
      test_stall();
      test_stall_flush();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
